// File: rtl/cache_setassoc_wb.sv
// N-way set-associative write-back / write-allocate data cache with per-set round-robin replacement.
// Optional `CACHE_STATS_EN adds hit/miss/write-back counters as extra output ports.
module cache_setassoc_wb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);
  localparam int BO_W  = $clog2(DATA_W/8);
  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int IX_W  = $clog2(SETS);
  localparam int TAG_W = ADDR_W - BO_W - WO_W - IX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WO_W-1:0] LAST = WO_W'(LINE_WORDS-1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [WO_W-1:0]           beat_q, beat_d, beat_n;
  logic [WAY_W-1:0]          vic_q, vic_d;
  logic                      cpu_ready_q, cpu_ready_d, cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0]         cpu_rdata_q, cpu_rdata_d;
  logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;

  logic [WAYS-1:0][SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
  logic [DATA_W-1:0]         data_q [WAYS][SETS][LINE_WORDS];
  logic [WAY_W-1:0]          vptr_q [SETS];

  logic [IX_W-1:0]           idx;
  logic [TAG_W-1:0]          req_tag;
  logic [WO_W-1:0]           word;
  logic                      hit, inv_found;
  logic [WAY_W-1:0]          hit_way, inv_way, vic_sel, vptr_new;
  logic                      data_we, dirty_set, fill_done;
  logic [WAY_W-1:0]          data_way;
  logic [WO_W-1:0]           data_word;
  logic [DATA_W-1:0]         data_val;
  logic                      unused_bits;

  assign idx         = addr_q[BO_W+WO_W +: IX_W];
  assign req_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign word        = addr_q[BO_W +: WO_W];
  assign unused_bits = ^addr_q[BO_W-1:0];
  assign vptr_new    = (WAYS == 1) ? '0 : vic_q + 1'b1;

  // Tag compare across all ways; the descending scan leaves the lowest invalid way selected.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[w][idx]) begin
        if (tag_q[w][idx] == req_tag) begin
          hit     = 1'b1;
          hit_way = WAY_W'(w);
        end
      end else begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vic_sel = inv_found ? inv_way : vptr_q[idx];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    vic_d       = vic_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_way    = vic_q;
    data_word   = word;
    data_val    = wdata_q;
    dirty_set   = 1'b0;
    fill_done   = 1'b0;
    // Beat to present: the current one when starting a phase, else the one after the ack.
    beat_n      = mem_req_q ? beat_q + 1'b1 : beat_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d  = cpu_addr;
        we_d    = cpu_we;
        wdata_d = cpu_wdata;
        state_d = LOOKUP;
      end
      LOOKUP: if (hit) begin
        cpu_ready_d = 1'b1;
        cpu_hit_d   = 1'b1;
        cpu_rdata_d = we_q ? wdata_q : data_q[hit_way][idx][word];
        data_we     = we_q;
        dirty_set   = we_q;
        data_way    = hit_way;
        state_d     = IDLE;
      end else begin
        vic_d   = vic_sel;
        beat_d  = '0;
        state_d = (valid_q[vic_sel][idx] && dirty_q[vic_sel][idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: if (!mem_req_q || mem_ack) begin
        if (mem_req_q && beat_q == LAST) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          state_d   = REFILL;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          beat_d      = beat_n;
          mem_addr_d  = {tag_q[vic_q][idx], idx, beat_n, {BO_W{1'b0}}};
          mem_wdata_d = data_q[vic_q][idx][beat_n];
        end
      end
      REFILL: if (!mem_req_q || mem_ack) begin
        if (mem_req_q) begin
          data_we   = 1'b1;
          data_word = beat_q;
          data_val  = mem_rdata;
        end
        if (mem_req_q && beat_q == LAST) begin
          mem_req_d = 1'b0;
          fill_done = 1'b1;
          state_d   = RESPOND;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          beat_d     = beat_n;
          mem_addr_d = {req_tag, idx, beat_n, {BO_W{1'b0}}};
        end
      end
      RESPOND: begin
        cpu_ready_d = 1'b1;
        cpu_rdata_d = we_q ? wdata_q : data_q[vic_q][idx][word];
        data_we     = we_q;
        dirty_set   = we_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      vic_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      vic_q       <= vic_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (dirty_set) dirty_q[data_way][idx] <= 1'b1;
      if (fill_done) begin
        valid_q[vic_q][idx] <= 1'b1;
        dirty_q[vic_q][idx] <= 1'b0;
        vptr_q[idx]         <= vptr_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && !rst) data_q[data_way][idx][data_word] <= data_val;
    if (fill_done && !rst) tag_q[vic_q][idx] <= req_tag;
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'd0, (state_q == LOOKUP) && hit};
    miss_cnt_d = miss_cnt_q + {31'd0, state_q == RESPOND};
    wb_cnt_d   = wb_cnt_q   + {31'd0, (state_q == WRITEBACK) && mem_req_q && mem_ack && (beat_q == LAST)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_cache_setassoc_wb.sv
// Bench for cache_setassoc_wb: directed vector table, reset-abort sequence, then random traffic
// checked against an architectural memory image plus a per-set replacement model.
module tb_cache_setassoc_wb;
  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  cache_setassoc_wb dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  // Main memory: word value = byte address at start, ack after `lat` request cycles.
  logic [31:0] mem [16384];
  bit          mem_inited = 1'b0;
  int          lat = 3;
  int          cnt = 0;
  int          req_cycles = 0;
  logic [15:0] log_a [$];
  logic [31:0] log_d [$];
  bit          log_we [$];

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'(i * 4);
      mem_inited = 1'b1;
    end
    if (rst) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      req_cycles++;
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr[15:2]] = mem_wdata;
        else mem_rdata = mem[mem_addr[15:2]];
        log_a.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_d.push_back(mem_we ? mem_wdata : mem[mem_addr[15:2]]);
      end
    end else begin
      cnt = 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One CPU transaction; returns response fields, latency in cycles and log/req snapshots.
  task automatic run_req(input bit we, input logic [15:0] a, input logic [31:0] wd,
                         output bit got, output bit hit, output logic [31:0] rd, output int lt,
                         output bit one_shot, output int log0, output int req0);
    log0 = log_a.size();
    req0 = req_cycles;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    lt = 0;
    while (!cpu_ready && lt < 400) begin
      @(negedge clk);
      lt++;
    end
    got = cpu_ready;
    hit = cpu_hit;
    rd  = cpu_rdata;
    @(negedge clk);
    one_shot = !cpu_ready;
  endtask

  task automatic chk_beats(input int start, input int nwr, input int nrd, input logic [15:0] rb,
                           input logic [15:0] wb, input logic [3:0][31:0] wbd);
    int w = 0;
    int r = 0;
    for (int k = start; k < log_a.size(); k++) begin
      if (log_we[k]) begin
        if (w < 4) begin
          chk("wb_addr", {16'd0, log_a[k]}, {16'd0, wb + 16'(4 * w)});
          chk("wb_data", log_d[k], wbd[w]);
        end
        w++;
      end else begin
        if (r < 4) chk("rf_addr", {16'd0, log_a[k]}, {16'd0, rb + 16'(4 * r)});
        r++;
      end
    end
    chk("n_wr_beats", 32'(w), 32'(nwr));
    chk("n_rd_beats", 32'(r), 32'(nrd));
  endtask

  typedef struct {
    bit               we;
    logic [15:0]      addr;
    logic [31:0]      wd;
    bit               hit;
    logic [31:0]      rdata;
    int               nwr;
    int               nrd;
    logic [15:0]      rb;
    logic [15:0]      wb;
    logic [3:0][31:0] wbd;
  } vec_t;

  function automatic vec_t mk(bit we, logic [15:0] a, logic [31:0] wd, bit h, logic [31:0] rd,
                              int nwr, int nrd, logic [15:0] rb, logic [15:0] wb,
                              logic [3:0][31:0] wbd);
    vec_t v;
    v.we = we; v.addr = a; v.wd = wd; v.hit = h; v.rdata = rd;
    v.nwr = nwr; v.nrd = nrd; v.rb = rb; v.wb = wb; v.wbd = wbd;
    return v;
  endfunction

  // Reference model: architectural memory image plus per-set tags/valid/dirty/pointer.
  logic [31:0] sh [16384];
  logic [7:0]  rtag [2][16];
  bit          rv [2][16];
  bit          rdirty [2][16];
  int          rptr [16];

  task automatic model(input bit we, input logic [15:0] a, input logic [31:0] wd,
                       output bit ehit, output logic [31:0] erd, output int nwr,
                       output logic [15:0] wb, output logic [3:0][31:0] wbd);
    int idx = int'(a[7:4]);
    int v = 0;
    ehit = 1'b0; nwr = 0; wb = '0; wbd = '0;
    for (int w = 0; w < 2; w++)
      if (rv[w][idx] && rtag[w][idx] == a[15:8]) begin ehit = 1'b1; v = w; end
    if (!ehit) begin
      v = rptr[idx];
      for (int w = 1; w >= 0; w--) if (!rv[w][idx]) v = w;
      if (rv[v][idx] && rdirty[v][idx]) begin
        nwr = 4;
        wb = {rtag[v][idx], a[7:4], 4'h0};
        for (int i = 0; i < 4; i++) wbd[i] = sh[int'(wb[15:2]) + i];
      end
      rtag[v][idx] = a[15:8];
      rv[v][idx] = 1'b1;
      rdirty[v][idx] = 1'b0;
      rptr[idx] = (v + 1) % 2;
    end
    if (we) begin
      sh[a[15:2]] = wd;
      rdirty[v][idx] = 1'b1;
    end
    erd = sh[a[15:2]];
  endtask

  vec_t vec [7];

  initial begin
    bit got, hit, one_shot, ehit;
    logic [31:0] rd, erd;
    logic [15:0] a, ewb;
    logic [3:0][31:0] ewbd;
    int lt, log0, req0, enwr, n;

    vec[0] = mk(0, 16'h0008, 0, 0, 32'h00000008, 0, 4, 16'h0000, 0, '0);
    vec[1] = mk(0, 16'h0008, 0, 1, 32'h00000008, 0, 0, 0, 0, '0);
    vec[2] = mk(1, 16'h0008, 32'hAABBCCDD, 1, 0, 0, 0, 0, 0, '0);
    vec[3] = mk(0, 16'h0008, 0, 1, 32'hAABBCCDD, 0, 0, 0, 0, '0);
    vec[4] = mk(0, 16'h0108, 0, 0, 32'h00000108, 0, 4, 16'h0100, 0, '0);
    vec[5] = mk(0, 16'h0208, 0, 0, 32'h00000208, 4, 4, 16'h0200, 16'h0000,
                {32'h0000000C, 32'hAABBCCDD, 32'h00000004, 32'h00000000});
    vec[6] = mk(0, 16'h0008, 0, 0, 32'hAABBCCDD, 0, 4, 16'h0000, 0, '0);

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_req(vec[i].we, vec[i].addr, vec[i].wd, got, hit, rd, lt, one_shot, log0, req0);
      chk("vec_ready", {31'd0, got}, 1);
      chk("vec_hit", {31'd0, hit}, {31'd0, vec[i].hit});
      if (!vec[i].we) chk("vec_rdata", rd, vec[i].rdata);
      chk("vec_ready_pulse", {31'd0, one_shot}, 1);
      if (vec[i].hit) begin
        chk("vec_hit_latency", 32'(lt), 1);
        chk("vec_hit_no_mem_req", 32'(req_cycles - req0), 0);
      end
      chk_beats(log0, vec[i].nwr, vec[i].nrd, vec[i].rb, vec[i].wb, vec[i].wbd);
    end

    // Reset in the middle of a refill abandons it.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0408;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 200) begin @(negedge clk); n++; end
    chk("abort_refill_started", {31'd0, mem_req && !mem_we}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 0);
    chk("abort_cpu_ready", {31'd0, cpu_ready}, 0);
    rst = 1'b0;
    run_req(0, 16'h0208, 0, got, hit, rd, lt, one_shot, log0, req0);
    chk("post_rst_ready", {31'd0, got}, 1);
    chk("post_rst_hit", {31'd0, hit}, 0);
    chk("post_rst_rdata", rd, 32'h00000208);

    // Random traffic over two sets and four tags to force conflicts and evictions.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16384; i++) sh[i] = mem[i];
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin rv[w][s] = 0; rdirty[w][s] = 0; end
    for (int s = 0; s < 16; s++) rptr[s] = 0;
    for (int t = 0; t < 300; t++) begin
      bit we;
      logic [31:0] wd;
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      a   = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00};
      lat = $urandom_range(1, 4);
      model(we, a, wd, ehit, erd, enwr, ewb, ewbd);
      run_req(we, a, wd, got, hit, rd, lt, one_shot, log0, req0);
      chk("rnd_ready", {31'd0, got}, 1);
      chk("rnd_hit", {31'd0, hit}, {31'd0, ehit});
      if (!we) chk("rnd_rdata", rd, erd);
      if (ehit) chk("rnd_hit_latency", 32'(lt), 1);
      chk_beats(log0, enwr, ehit ? 0 : 4, {a[15:4], 4'h0}, ewb, ewbd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_setassoc_wb.md
Name: cache_setassoc_wb

Overview:
- Parametrised N-way set-associative data cache controller with write-back and write-allocate policy.
- Successor to the direct-mapped write-through cache in memory_system_top; keeps the same CPU-side interface.
- Adds configurable associativity and per-set round-robin replacement.
- Adds dirty-line eviction over a word-serial memory handshake.
- Sits between the CPU request port and main memory.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 32, word width (multiple of 8); byte offset bits = log2(DATA_W/8)
WAYS, 2, associativity; power of 2, 1..4
SETS, 16, sets per way; power of 2
LINE_WORDS, 4, words per line; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req  in  1  request strobe; sampled only in IDLE
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address, word-aligned
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  valid with cpu_ready; 1=hit
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
mem_req  out  1  memory word request, held until mem_ack
mem_we  out  1  1=write beat, 0=read beat
mem_addr  out  ADDR_W  word-aligned byte address of current beat
mem_wdata  out  DATA_W  write-beat data
mem_ack  in  1  one-cycle beat accept / read data valid
mem_rdata  in  DATA_W  read data, valid when mem_ack=1

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Address split, LSB first: byte offset; word offset log2(LINE_WORDS); index log2(SETS); tag = remaining bits.
- Per line storage: valid bit, dirty bit, tag, LINE_WORDS data words.
- Per set storage: victim pointer, log2(WAYS) bits (0 bits when WAYS=1).
- Reset, at the clk edge with rst=1:
  - FSM returns to IDLE.
  - All valid bits, dirty bits and victim pointers clear.
  - cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata all 0.
  - Any in-flight memory transaction is abandoned; a partial write-back is not repaired.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - cpu_req=1 latches addr, we and wdata, then goes to LOOKUP.
  - cpu_req in any other state is ignored.
- LOOKUP: all ways compared in parallel.
  - Hit, read: cpu_rdata = hit word.
  - Hit, write: word updated and dirty=1; no memory traffic.
  - Hit, either: cpu_ready=1 and cpu_hit=1 registered for one cycle, then back to IDLE. Hit latency is ready one cycle after the request edge.
  - Miss: victim = lowest-index invalid way if any, else the set's victim pointer. Go to WRITEBACK if the victim is valid and dirty, else to REFILL.
- WRITEBACK:
  - Issues LINE_WORDS write beats, word 0 first, at {victim tag, index, word, 0}.
  - Each beat holds mem_req, mem_we=1, mem_addr and mem_wdata stable until mem_ack.
  - After mem_ack, the next beat is presented on the following cycle.
  - After the last ack, goes to REFILL.
- REFILL:
  - Issues LINE_WORDS read beats, word 0 first, at the request line address; each acked word is written into the victim way.
  - After the last ack: victim tag and valid=1 set, dirty=0, victim pointer = (chosen way + 1) mod WAYS. Goes to RESPOND.
- RESPOND:
  - Write request: merges cpu_wdata into the refilled line and sets dirty=1.
  - Read request: cpu_rdata = refilled word.
  - cpu_ready=1, cpu_hit=0 for one cycle, then IDLE.
- Memory beats:
  - mem_ack when mem_req=0 is ignored.
  - mem_req drops in the cycle after the final ack of a phase.
  - No zero-wait assumption; a beat may stall indefinitely.
- WAYS=1 degenerates to a direct-mapped write-back cache.

Optional Feature:
CACHE_STATS_EN
- Defined:
  - Adds output ports hit_count, miss_count, wb_count, each 32 bits, cleared by rst, wrapping on overflow.
  - hit_count increments on each hit response.
  - miss_count increments on each miss response.
  - wb_count increments once per completed line write-back.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
Common setup: defaults (WAYS=2, SETS=16, LINE_WORDS=4); memory model returns word value = its byte address; ack latency 3 cycles.
1. Cold miss: read 0x0008 after reset -> read beats at 0x0000, 0x0004, 0x0008, 0x000C; then cpu_ready=1, cpu_hit=0, cpu_rdata=0x00000008.
2. Read hit: read 0x0008 -> cpu_ready one cycle after the request edge, cpu_hit=1, rdata 0x00000008, mem_req never asserted.
3. Write hit: write 0x0008 = 0xAABBCCDD -> cpu_hit=1, no mem write beat. Read 0x0008 -> hit, 0xAABBCCDD.
4. Second way: read 0x0108 (set 0) -> miss, fills way 1, no write-back, rdata 0x00000108.
5. Dirty eviction: read 0x0208 -> victim way 0 -> write beats 0x0000..0x000C with data 0x0, 0x4, 0xAABBCCDD, 0xC; then refill; rdata 0x00000208, hit=0.
6. Clean eviction and reset: read 0x0008 -> evicts way 1 (0x0108 line) with no write beats, rdata 0xAABBCCDD. Assert rst during a later refill -> next cycle mem_req=0, and a subsequent read of 0x0208 misses.
